// File: rtl/ppu_pkg.sv
// Shared PPU types: background pixel format, Mode 7 line FSM states and
// the screen-over actions selected by m7sel[7:6].
package ppu_pkg;

  typedef struct packed {
    logic [7:0] color;
    logic       prio;
  } bg_pixel_type;

  typedef enum logic [1:0] {
    M7_IDLE,
    M7_SETUP0,
    M7_SETUP1,
    M7_RUN
  } m7_state_t;

  // Out-of-range handling; 2'b01 behaves like wrap.
  localparam logic [1:0] M7_OVER_WRAP   = 2'b00;
  localparam logic [1:0] M7_OVER_TRANSP = 2'b10;
  localparam logic [1:0] M7_OVER_TILE0  = 2'b11;

endpackage

// File: rtl/m7_coord_acc.sv
// One Mode 7 coordinate accumulator (used once for X, once for Y).
// Loads the line start value from the two shared products plus the rotation
// origin (and the x-flip pre-advance), then steps by +/-delta per pixel.
// Exposes the 10-bit integer coordinate and an out-of-range flag.
module m7_coord_acc
  import ppu_pkg::*;
#(
  parameter int COORD_W = 13,
  parameter int MAT_W   = 16,
  parameter int FRAC_W  = 8,
  parameter int ACC_W   = 24,
  parameter int LINE_W  = 256,
  parameter int PROD_W  = MAT_W + COORD_W + 1
) (
  input  logic                      clk,
  input  logic                      en,
  input  logic                      load,
  input  logic                      step,
  input  logic                      flip,
  input  logic signed [PROD_W-1:0]  prod_a,
  input  logic signed [PROD_W-1:0]  prod_b,
  input  logic signed [COORD_W-1:0] orig,
  input  logic signed [MAT_W-1:0]   delta,
  output logic [9:0]                ipart,
  output logic                      oob
);

  logic signed [ACC_W-1:0] acc_p0;
  logic signed [ACC_W-1:0] delta_sx;
  logic signed [ACC_W-1:0] orig_sx;
  logic signed [ACC_W-1:0] pre_adv;
  logic signed [ACC_W-1:0] load_val;
  logic signed [ACC_W-1:0] step_val;

  assign delta_sx = ACC_W'(delta);
  assign orig_sx  = ACC_W'(orig);
  // Flipped lines start at the right edge and walk back towards x=0.
  assign pre_adv  = flip ? ACC_W'(delta_sx * ACC_W'(LINE_W - 1)) : '0;
  // Truncating each product before the add gives the same wrapped sum.
  assign load_val = ACC_W'(prod_a) + ACC_W'(prod_b) + (orig_sx <<< FRAC_W) + pre_adv;
  assign step_val = flip ? -delta_sx : delta_sx;

  // Accumulator: line-start load, then one step per pixel; no reset needed.
  always_ff @(posedge clk) begin
    if (en) begin
      if (load) begin
        acc_p0 <= load_val;
      end else if (step) begin
        acc_p0 <= acc_p0 + step_val;
      end
    end
  end

  assign ipart = acc_p0[FRAC_W+9:FRAC_W];
  assign oob   = |acc_p0[ACC_W-1:FRAC_W+10];

endmodule

// File: rtl/bg7_line_renderer.sv
// Mode 7 per-scanline BG renderer. Two setup cycles compute the line start
// coordinates through two shared multipliers, then each pixel spends one
// dot on the tilemap fetch (dot_ctr[0]=0) and one on the character fetch
// (dot_ctr[0]=1). VRAM data for an address registered on one dot_en edge is
// valid during the following dot, so the pixel is formatted one dot later.
module bg7_line_renderer
  import ppu_pkg::*;
#(
  parameter int COORD_W = 13,
  parameter int MAT_W   = 16,
  parameter int FRAC_W  = 8,
  parameter int ACC_W   = 24,
  parameter int LINE_W  = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dot_en,
  input  logic [2:0]                dot_ctr,
  input  logic                      line_start,
  input  logic [7:0]                y,
  input  logic [7:0]                m7sel,
  input  logic                      extbg,
  input  logic signed [MAT_W-1:0]   m7_a,
  input  logic signed [MAT_W-1:0]   m7_b,
  input  logic signed [MAT_W-1:0]   m7_c,
  input  logic signed [MAT_W-1:0]   m7_d,
  input  logic signed [COORD_W-1:0] m7_xofs,
  input  logic signed [COORD_W-1:0] m7_yofs,
  input  logic signed [COORD_W-1:0] m7_xorig,
  input  logic signed [COORD_W-1:0] m7_yorig,
  output logic [14:0]               vram_l_addr,
  output logic [14:0]               vram_h_addr,
  input  logic [7:0]                vram_rdata_l,
  input  logic [7:0]                vram_rdata_h,
  output bg_pixel_type              pixel,
  output logic                      pixel_valid,
  output logic [7:0]                pixel_x,
  output logic                      busy
);

  localparam int DIF_W  = COORD_W + 1;
  localparam int PROD_W = MAT_W + COORD_W + 1;
  localparam logic [7:0] LAST_X = 8'(LINE_W - 1);

  m7_state_t               state;
  logic [7:0]              y_p0;
  logic [7:0]              px_cnt;
  logic                    fetched_p0;
  logic                    vld_p1;
  logic                    transp_p1;
  logic [7:0]              x_p1;
  logic [7:0]              yy;
  logic signed [DIF_W-1:0] dx;
  logic signed [DIF_W-1:0] dy;
  logic signed [MAT_W-1:0] mul_x;
  logic signed [MAT_W-1:0] mul_y;
  logic signed [PROD_W-1:0] prod_dx;
  logic signed [PROD_W-1:0] prod_dy;
  logic [9:0]              ix;
  logic [9:0]              iy;
  logic                    oob_x;
  logic                    oob_y;
  logic [1:0]              over_mode;
  logic [7:0]              tile;
  logic                    step_en;
  logic                    unused_ctl;

  // Only the fetch phase bit and the flip/over fields steer this block.
  assign unused_ctl = ^{dot_ctr[2:1], m7sel[5:2]};

  function automatic bg_pixel_type fmt_pixel(input logic [7:0] raw, input logic ext,
                                             input logic transp);
    bg_pixel_type p;
    p = '0;
    if (!transp) begin
      if (ext) begin
        p.color = {1'b0, raw[6:0]};
        p.prio  = raw[7];
      end else begin
        p.color = raw;
        p.prio  = 1'b0;
      end
    end
    return p;
  endfunction

  assign yy = m7sel[1] ? ~y_p0 : y_p0;
  assign dx = DIF_W'(m7_xofs) - DIF_W'(m7_xorig);
  assign dy = $signed(DIF_W'(yy)) + DIF_W'(m7_yofs) - DIF_W'(m7_yorig);

  // Shared multipliers: A/B feed the X setup, C/D the Y setup.
  assign mul_x   = (state == M7_SETUP0) ? m7_a : m7_c;
  assign mul_y   = (state == M7_SETUP0) ? m7_b : m7_d;
  assign prod_dx = PROD_W'(mul_x) * PROD_W'(dx);
  assign prod_dy = PROD_W'(mul_y) * PROD_W'(dy);

  assign step_en = (state == M7_RUN) && dot_ctr[0] && fetched_p0;

  m7_coord_acc #(
    .COORD_W(COORD_W), .MAT_W(MAT_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W), .LINE_W(LINE_W)
  ) u_acc_x (
    .clk(clk), .en(dot_en), .load(state == M7_SETUP0), .step(step_en), .flip(m7sel[0]),
    .prod_a(prod_dx), .prod_b(prod_dy), .orig(m7_xorig), .delta(m7_a),
    .ipart(ix), .oob(oob_x)
  );

  m7_coord_acc #(
    .COORD_W(COORD_W), .MAT_W(MAT_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W), .LINE_W(LINE_W)
  ) u_acc_y (
    .clk(clk), .en(dot_en), .load(state == M7_SETUP1), .step(step_en), .flip(m7sel[0]),
    .prod_a(prod_dx), .prod_b(prod_dy), .orig(m7_yorig), .delta(m7_c),
    .ipart(iy), .oob(oob_y)
  );

  // In-range pixels always wrap; out-of-range ones follow m7sel[7:6].
  assign over_mode = (oob_x || oob_y) ? m7sel[7:6] : M7_OVER_WRAP;
  assign tile      = (over_mode == M7_OVER_TILE0) ? 8'h00 : vram_rdata_l;

  // Line FSM, VRAM address issue and pixel output, all advancing on dot_en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= M7_IDLE;
      y_p0        <= '0;
      px_cnt      <= '0;
      fetched_p0  <= 1'b0;
      vld_p1      <= 1'b0;
      transp_p1   <= 1'b0;
      x_p1        <= '0;
      vram_l_addr <= '0;
      vram_h_addr <= '0;
      pixel       <= '0;
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      busy        <= 1'b0;
    end else if (dot_en) begin
      // p1 -> output: format the character byte; an abort drops it
      pixel_valid <= 1'b0;
      vld_p1      <= 1'b0;
      if (vld_p1 && !line_start) begin
        pixel_valid <= 1'b1;
        pixel_x     <= x_p1;
        pixel       <= fmt_pixel(vram_rdata_h, extbg, transp_p1);
      end
      if (pixel_valid && (pixel_x == LAST_X)) begin
        busy <= 1'b0;
      end
      if (line_start) begin
        state      <= M7_SETUP0;
        y_p0       <= y;
        px_cnt     <= '0;
        fetched_p0 <= 1'b0;
        busy       <= 1'b1;
      end else begin
        case (state)
          M7_IDLE:   state <= M7_IDLE;
          M7_SETUP0: state <= M7_SETUP1;
          M7_SETUP1: state <= M7_RUN;
          M7_RUN: begin
            // p0: tilemap fetch
            if (!dot_ctr[0]) begin
              vram_l_addr <= {1'b0, iy[9:3], ix[9:3]};
              fetched_p0  <= 1'b1;
            // p0 -> p1: character fetch, then step to the next pixel
            end else if (fetched_p0) begin
              vram_h_addr <= {1'b0, tile, iy[2:0], ix[2:0]};
              fetched_p0  <= 1'b0;
              vld_p1      <= 1'b1;
              x_p1        <= px_cnt;
              transp_p1   <= (over_mode == M7_OVER_TRANSP);
              if (px_cnt == LAST_X) begin
                state <= M7_IDLE;
              end else begin
                px_cnt <= px_cnt + 8'd1;
              end
            end
          end
          default: state <= M7_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bg7_line_renderer.sv
// Bench for bg7_line_renderer: a line model pushes all expected pixels of a
// line at line_start; each pixel_valid pops and compares one entry.
module tb_bg7_line_renderer;
  import ppu_pkg::*;

  logic               clk;
  logic               reset;
  logic               dot_en;
  logic [2:0]         dot_ctr;
  logic               line_start;
  logic [7:0]         y;
  logic [7:0]         m7sel;
  logic               extbg;
  logic signed [15:0] m7_a, m7_b, m7_c, m7_d;
  logic signed [12:0] m7_xofs, m7_yofs, m7_xorig, m7_yorig;
  logic [14:0]        vram_l_addr, vram_h_addr;
  logic [7:0]         vram_rdata_l, vram_rdata_h;
  bg_pixel_type       pixel;
  logic               pixel_valid;
  logic [7:0]         pixel_x;
  logic               busy;

  logic [7:0] mem_l [32768];
  logic [7:0] mem_h [32768];

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  color;
    logic        prio;
    logic [14:0] h_addr;
    logic        chk_h;
    logic [14:0] l_next;
  } exp_t;

  exp_t         sb [$];
  int           checks = 0;
  int           errors = 0;
  int           dots = 0;
  int           last_x = -1;
  bg_pixel_type last_pix;

  bg7_line_renderer dut (
    .clk(clk), .reset(reset), .dot_en(dot_en), .dot_ctr(dot_ctr),
    .line_start(line_start), .y(y), .m7sel(m7sel), .extbg(extbg),
    .m7_a(m7_a), .m7_b(m7_b), .m7_c(m7_c), .m7_d(m7_d),
    .m7_xofs(m7_xofs), .m7_yofs(m7_yofs), .m7_xorig(m7_xorig), .m7_yorig(m7_yorig),
    .vram_l_addr(vram_l_addr), .vram_h_addr(vram_h_addr),
    .vram_rdata_l(vram_rdata_l), .vram_rdata_h(vram_rdata_h),
    .pixel(pixel), .pixel_valid(pixel_valid), .pixel_x(pixel_x), .busy(busy)
  );

  assign vram_rdata_l = mem_l[vram_l_addr];
  assign vram_rdata_h = mem_h[vram_h_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic longint wrap_s(input longint v, input int w);
    longint m;
    m = longint'(1) << w;
    v = v % m;
    if (v < 0) v += m;
    if (v >= m / 2) v -= m;
    return v;
  endfunction

  // Model of one full line, pushed in emission order.
  task automatic push_line(input logic [7:0] yv);
    longint a, b, c, d, dx, dy, yy, x0, y0, sxs, sys, xv, yv2;
    int ix, iy;
    bit oob;
    logic [1:0] md;
    logic [7:0] yf, tile, raw;
    logic [14:0] la [256];
    exp_t ex [256];
    a = longint'(m7_a); b = longint'(m7_b); c = longint'(m7_c); d = longint'(m7_d);
    md = m7sel[7:6];
    yf = m7sel[1] ? ~yv : yv;
    yy = longint'(yf);
    dx = wrap_s(longint'(m7_xofs) - longint'(m7_xorig), 14);
    dy = wrap_s(yy + longint'(m7_yofs) - longint'(m7_yorig), 14);
    x0 = a * dx + b * dy + longint'(m7_xorig) * 256 + (m7sel[0] ? a * 255 : 0);
    y0 = c * dx + d * dy + longint'(m7_yorig) * 256 + (m7sel[0] ? c * 255 : 0);
    sxs = m7sel[0] ? -a : a;
    sys = m7sel[0] ? -c : c;
    for (int n = 0; n < 256; n++) begin
      xv = (x0 + longint'(n) * sxs) & 64'hFFFFFF;
      yv2 = (y0 + longint'(n) * sys) & 64'hFFFFFF;
      ix = int'((xv >> 8) & 1023);
      iy = int'((yv2 >> 8) & 1023);
      oob = ((xv >> 18) != 0) || ((yv2 >> 18) != 0);
      la[n] = 15'((iy / 8) * 128 + (ix / 8));
      tile = (oob && md == 2'b11) ? 8'h00 : mem_l[la[n]];
      ex[n].x = 8'(n);
      ex[n].h_addr = 15'(int'(tile) * 64 + (iy % 8) * 8 + (ix % 8));
      ex[n].chk_h = !(oob && md == 2'b10);
      raw = mem_h[ex[n].h_addr];
      if (oob && md == 2'b10) begin
        ex[n].color = 8'h00; ex[n].prio = 1'b0;
      end else if (extbg) begin
        ex[n].color = {1'b0, raw[6:0]}; ex[n].prio = raw[7];
      end else begin
        ex[n].color = raw; ex[n].prio = 1'b0;
      end
    end
    for (int n = 0; n < 256; n++) begin
      ex[n].l_next = la[(n < 255) ? n + 1 : 255];
      sb.push_back(ex[n]);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (pixel_valid) begin
      if (sb.size() == 0) begin
        chk("pending_pixels", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("pixel_x@%0d", e.x), pixel_x, e.x);
        chk($sformatf("color@%0d", e.x), pixel.color, e.color);
        chk($sformatf("prio@%0d", e.x), pixel.prio, e.prio);
        chk($sformatf("l_addr_next@%0d", e.x), vram_l_addr, e.l_next);
        if (e.chk_h) chk($sformatf("h_addr@%0d", e.x), vram_h_addr, e.h_addr);
        chk($sformatf("busy@%0d", e.x), busy, 1);
        if (e.x == 8'd0) chk("first_latency", dots, 5);
        last_x = int'(pixel_x);
        last_pix = pixel;
      end
    end
  endtask

  // One dot_en edge, sometimes preceded by a stalled (dot_en=0) clock.
  task automatic step_dot();
    if ($urandom_range(0, 3) == 0) begin
      dot_en = 1'b0;
      @(posedge clk); #1;
    end
    dot_en = 1'b1;
    @(posedge clk); #1;
    dot_en = 1'b0;
    dot_ctr = dot_ctr + 3'd1;
    if (line_start) dots = 0;
    else dots++;
    monitor();
  endtask

  task automatic start_line(input logic [7:0] yv);
    if (dot_ctr[0] == 1'b0) step_dot();
    sb.delete();
    push_line(yv);
    last_x = -1;
    y = yv;
    line_start = 1'b1;
    step_dot();
    line_start = 1'b0;
    chk("busy_start", busy, 1);
  endtask

  task automatic finish_line(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 1200) begin
      step_dot();
      n++;
    end
    chk({tag, "_left"}, sb.size(), 0);
    step_dot();
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_valid_end"}, pixel_valid, 0);
  endtask

  task automatic run_until_x(input int stop_x);
    int n;
    n = 0;
    while (last_x != stop_x && n < 1200) begin
      step_dot();
      n++;
    end
    chk("reach_x", last_x, stop_x);
  endtask

  task automatic set_identity();
    m7_a = 16'sh0100; m7_b = 16'sh0000; m7_c = 16'sh0000; m7_d = 16'sh0100;
    m7_xofs = '0; m7_yofs = '0; m7_xorig = '0; m7_yorig = '0;
    m7sel = 8'h00; extbg = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_pixel"}, pixel, 0);
    chk({tag, "_valid"}, pixel_valid, 0);
    chk({tag, "_x"}, pixel_x, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_l_addr"}, vram_l_addr, 0);
    chk({tag, "_h_addr"}, vram_h_addr, 0);
  endtask

  initial begin
    reset = 1'b1; dot_en = 1'b0; dot_ctr = 3'd0; line_start = 1'b0; y = 8'd0;
    set_identity();
    for (int i = 0; i < 32768; i++) begin
      mem_l[i] = 8'($urandom);
      mem_h[i] = 8'($urandom);
    end
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    reset = 1'b0;

    // identity and 2x zoom
    start_line(8'd0); finish_line("identity");
    m7_a = 16'sh0080;
    start_line(8'd0); finish_line("zoom");
    m7_a = 16'sh0100;

    // screen-over modes past the 1024 boundary
    m7_xofs = 13'sd1020;
    m7sel = 8'h80; start_line(8'd0); finish_line("over_transp");
    m7sel = 8'hC0; start_line(8'd0); finish_line("over_tile0");
    m7sel = 8'h00; start_line(8'd0); finish_line("over_wrap");
    m7_xofs = '0;

    // flips
    m7sel = 8'h01; start_line(8'd0); finish_line("xflip");
    m7sel = 8'h02; start_line(8'd0); finish_line("yflip");

    // rotation with scroll, origin and both flips
    m7_a = 16'sh00B5; m7_b = 16'shFF4B; m7_c = 16'sh00B5; m7_d = 16'sh00B5;
    m7_xofs = 13'sd37; m7_yofs = -13'sd20; m7_xorig = 13'sd128; m7_yorig = 13'sd112;
    m7sel = 8'h03;
    start_line(8'd77); finish_line("rotate");

    // EXTBG with a fixed character byte
    set_identity();
    for (int i = 0; i < 32768; i++) mem_h[i] = 8'hC5;
    extbg = 1'b1; start_line(8'd3); finish_line("extbg1");
    chk("extbg1_color", last_pix.color, 8'h45);
    chk("extbg1_prio", last_pix.prio, 1);
    extbg = 1'b0; start_line(8'd3); finish_line("extbg0");
    chk("extbg0_color", last_pix.color, 8'hC5);
    chk("extbg0_prio", last_pix.prio, 0);
    for (int i = 0; i < 32768; i++) mem_h[i] = 8'($urandom);

    // restart mid-line
    m7_a = 16'sh00E0; m7_d = 16'sh0120; m7_yofs = 13'sd40;
    start_line(8'd10); run_until_x(100);
    start_line(8'd20); finish_line("abort");

    // async reset mid-line
    start_line(8'd5); run_until_x(50);
    #2;
    reset = 1'b1;
    #1;
    chk_outputs_zero("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    repeat (8) step_dot();
    chk("post_reset_busy", busy, 0);
    chk("post_reset_valid", pixel_valid, 0);
    start_line(8'd200); finish_line("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
